// File: rtl/dcache_sram_arbiter_pkg.sv
// ============================================================================
// Module   : dcache_sram_arbiter_pkg
// Brief    : dcache geometry, line/byte-enable types and arbiter select type.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dcache_sram_arbiter_pkg;

   localparam int DCACHE_SET_ASSOC   = 4;
   localparam int DCACHE_INDEX_WIDTH = 8;
   localparam int DCACHE_TAG_WIDTH   = 12;
   localparam int DCACHE_LINE_WIDTH  = 64;
   localparam int NR_CORE_PORTS      = 3;

   typedef logic [DCACHE_LINE_WIDTH-1:0]   cache_line_t;
   typedef logic [DCACHE_LINE_WIDTH/8-1:0] cl_be_t;

   // Requester select: 0 is the snoop port, 1..NR_CORE_PORTS are core ports.
   typedef logic [$clog2(NR_CORE_PORTS+1)-1:0] arb_sel_t;

   localparam arb_sel_t DCACHE_SNOOP_PORT = '0;

endpackage

`default_nettype wire

// File: rtl/dcache_sram_arbiter_rr_pick.sv
// ============================================================================
// Module   : dcache_sram_arbiter_rr_pick
// Brief    : Find-first set bit of an eligibility vector starting at a pointer,
//            wrapping from N-1 back to 0.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_sram_arbiter_rr_pick #(
   parameter int N  = 3,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  elig_i,
   input  logic [PW-1:0] ptr_i,
   output logic [PW-1:0] idx_o,
   output logic          valid_o
);

   always_comb begin : p_pick
      int k;
      valid_o = 1'b0;
      idx_o   = '0;
      k       = 0;
      // Scan from the farthest offset down so the nearest hit overwrites last.
      for (int o = N - 1; o >= 0; o--) begin
         k = (int'(ptr_i) + o) % N;
         if (elig_i[k]) begin
            valid_o = 1'b1;
            idx_o   = k[PW-1:0];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dcache_sram_arbiter.sv
// ============================================================================
// Module   : dcache_sram_arbiter
// Brief    : Shares the dcache SRAM port between the snoop controller (port 0)
//            and round-robin core ports, with starvation bound and late-tag mux.
//            Optional perf counters under macro DCACHE_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_sram_arbiter
   import dcache_sram_arbiter_pkg::*;
#(
   parameter int NrCorePorts = NR_CORE_PORTS,
   parameter int StarveMax   = 4
) (
   input  logic                                             clk_i,
   input  logic                                             rst_ni,
   input  logic [NrCorePorts:0][DCACHE_SET_ASSOC-1:0]       req_i,
   input  logic [NrCorePorts:0][DCACHE_INDEX_WIDTH-1:0]     addr_i,
   input  logic [NrCorePorts:0][DCACHE_TAG_WIDTH-1:0]       tag_i,
   input  logic [NrCorePorts:0]                             we_i,
   input  cache_line_t [NrCorePorts:0]                      data_i,
   input  cl_be_t [NrCorePorts:0]                           be_i,
   output logic [NrCorePorts:0]                             gnt_o,
   input  logic                                             snoop_busy_i,
   input  logic [DCACHE_INDEX_WIDTH-1:0]                    snoop_index_i,
   output logic [DCACHE_SET_ASSOC-1:0]                      sram_req_o,
   output logic [DCACHE_INDEX_WIDTH-1:0]                    sram_addr_o,
   output logic [DCACHE_TAG_WIDTH-1:0]                      sram_tag_o,
   output logic                                             sram_we_o,
   output cache_line_t                                      sram_data_o,
   output cl_be_t                                           sram_be_o,
   input  logic                                             sram_gnt_i,
   output logic [15:0]                                      snoop_grants_o,
   output logic [15:0]                                      starve_forced_o
);

   localparam int PW = (NrCorePorts > 1) ? $clog2(NrCorePorts) : 1;
   localparam int CW = $clog2(StarveMax + 1);
   localparam logic [CW-1:0] STARVE_MAX_C = CW'(StarveMax);
   localparam logic [PW-1:0] LAST_PTR_C   = PW'(NrCorePorts - 1);

   logic [PW-1:0]          rr_ptr_q;
   logic [CW-1:0]          starve_cnt_q;
   arb_sel_t               sel_q;

   logic [NrCorePorts-1:0] core_elig;
   logic [PW-1:0]          core_idx;
   logic                   core_vld;
   logic                   snoop_act;
   logic                   snoop_win;
   logic                   core_win;
   logic                   any_act;
   logic                   granted;
   arb_sel_t               winner;

   // A core write to the line the snoop is working on must wait.
   for (genvar i = 0; i < NrCorePorts; i++) begin : g_elig
      assign core_elig[i] = (|req_i[i+1]) &
                            ~(we_i[i+1] & snoop_busy_i & (addr_i[i+1] == snoop_index_i));
   end

   dcache_sram_arbiter_rr_pick #(
      .N  (NrCorePorts),
      .PW (PW)
   ) u_rr_pick (
      .elig_i  (core_elig),
      .ptr_i   (rr_ptr_q),
      .idx_o   (core_idx),
      .valid_o (core_vld)
   );

   assign snoop_act = |req_i[DCACHE_SNOOP_PORT];
   assign snoop_win = snoop_act & ((starve_cnt_q < STARVE_MAX_C) | ~core_vld);
   assign core_win  = ~snoop_win & core_vld;
   assign any_act   = snoop_win | core_win;
   assign granted   = any_act & sram_gnt_i;
   assign winner    = snoop_win ? DCACHE_SNOOP_PORT : (arb_sel_t'(core_idx) + arb_sel_t'(1));

   always_comb begin : p_mux
      gnt_o       = '0;
      sram_req_o  = '0;
      sram_addr_o = '0;
      sram_we_o   = 1'b0;
      sram_data_o = '0;
      sram_be_o   = '0;
      if (any_act) begin
         gnt_o[winner] = sram_gnt_i;
         sram_req_o    = req_i[winner];
         sram_addr_o   = addr_i[winner];
         sram_we_o     = we_i[winner];
         sram_data_o   = data_i[winner];
         sram_be_o     = be_i[winner];
      end
   end

   // Tag arrives a cycle late, so it follows the previous winner, not the current one.
   assign sram_tag_o = tag_i[sel_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin : p_state
      if (!rst_ni) begin
         rr_ptr_q     <= '0;
         starve_cnt_q <= '0;
         sel_q        <= '0;
      end else if (sram_gnt_i) begin
         if (granted) begin
            sel_q <= winner;
         end
         if (core_win) begin
            rr_ptr_q     <= (core_idx == LAST_PTR_C) ? '0 : core_idx + PW'(1);
            starve_cnt_q <= '0;
         end else if (!core_vld) begin
            starve_cnt_q <= '0;
         end else if (snoop_win && (starve_cnt_q != STARVE_MAX_C)) begin
            starve_cnt_q <= starve_cnt_q + CW'(1);
         end
      end
   end

`ifdef DCACHE_ARB_PERF_EN
   logic [15:0] snoop_grants_q;
   logic [15:0] starve_forced_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin : p_perf
      if (!rst_ni) begin
         snoop_grants_q  <= '0;
         starve_forced_q <= '0;
      end else begin
         if (snoop_win && sram_gnt_i && (snoop_grants_q != 16'hFFFF)) begin
            snoop_grants_q <= snoop_grants_q + 16'd1;
         end
         if (core_win && snoop_act && sram_gnt_i && (starve_forced_q != 16'hFFFF)) begin
            starve_forced_q <= starve_forced_q + 16'd1;
         end
      end
   end

   assign snoop_grants_o  = snoop_grants_q;
   assign starve_forced_o = starve_forced_q;
`else
   assign snoop_grants_o  = '0;
   assign starve_forced_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_sram_arbiter.sv
// ============================================================================
// Module   : tb_dcache_sram_arbiter
// Brief    : Directed self-checking bench for dcache_sram_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_sram_arbiter;
   import dcache_sram_arbiter_pkg::*;

`ifdef DCACHE_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                                     clk = 1'b0;
   logic                                     rst_n;
   logic [3:0][DCACHE_SET_ASSOC-1:0]         req;
   logic [3:0][DCACHE_INDEX_WIDTH-1:0]       addr;
   logic [3:0][DCACHE_TAG_WIDTH-1:0]         tag;
   logic [3:0]                               we;
   cache_line_t [3:0]                        data;
   cl_be_t [3:0]                             be;
   logic [3:0]                               gnt;
   logic                                     snoop_busy;
   logic [DCACHE_INDEX_WIDTH-1:0]            snoop_index;
   logic [DCACHE_SET_ASSOC-1:0]              sram_req;
   logic [DCACHE_INDEX_WIDTH-1:0]            sram_addr;
   logic [DCACHE_TAG_WIDTH-1:0]              sram_tag;
   logic                                     sram_we;
   cache_line_t                              sram_data;
   cl_be_t                                   sram_be;
   logic                                     sram_gnt;
   logic [15:0]                              snoop_grants;
   logic [15:0]                              starve_forced;

   int n_cmp = 0;
   int n_err = 0;

   dcache_sram_arbiter #(
      .NrCorePorts (3),
      .StarveMax   (4)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .req_i           (req),
      .addr_i          (addr),
      .tag_i           (tag),
      .we_i            (we),
      .data_i          (data),
      .be_i            (be),
      .gnt_o           (gnt),
      .snoop_busy_i    (snoop_busy),
      .snoop_index_i   (snoop_index),
      .sram_req_o      (sram_req),
      .sram_addr_o     (sram_addr),
      .sram_tag_o      (sram_tag),
      .sram_we_o       (sram_we),
      .sram_data_o     (sram_data),
      .sram_be_o       (sram_be),
      .sram_gnt_i      (sram_gnt),
      .snoop_grants_o  (snoop_grants),
      .starve_forced_o (starve_forced)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int r = 0; r < 4; r++) begin
         req[r]  = '0;
         addr[r] = 8'h10 + 8'(r);
         tag[r]  = 12'hA00 + 12'(r);
         we[r]   = 1'b0;
         data[r] = 64'hD0 + 64'(r);
         be[r]   = 8'hF0 | 8'(r);
      end
      snoop_busy  = 1'b0;
      snoop_index = '0;
      sram_gnt    = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      tick();
      rst_n = 1'b1;
   endtask

   logic [3:0] exp_t1 [6] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2, 4'h1};
   logic [3:0] exp_t2 [4] = '{4'h2, 4'h4, 4'h8, 4'h2};
   logic [3:0] exp_t6 [5] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h2};

   initial begin
      // Reset state
      rst_n = 1'b0;
      clear_inputs();
      #3;
      check("rst_gnt", 64'(gnt), 64'h0);
      check("rst_sram_req", 64'(sram_req), 64'h0);
      check("rst_snoop_grants", 64'(snoop_grants), 64'h0);
      check("rst_starve_forced", 64'(starve_forced), 64'h0);
      tick();
      rst_n = 1'b1;

      // Snoop vs core1: four snoop wins, then one forced core grant
      req[0] = 4'b0001;
      req[1] = 4'b0010;
      for (int c = 0; c < 6; c++) begin
         #2;
         check($sformatf("starve_gnt%0d", c), 64'(gnt), 64'(exp_t1[c]));
         if (c == 4) check("starve_core_addr", 64'(sram_addr), 64'h11);
         tick();
      end
      #2;
      check("starve_snoop_grants", 64'(snoop_grants), PERF ? 64'd5 : 64'd0);
      check("starve_forced_cnt", 64'(starve_forced), PERF ? 64'd1 : 64'd0);

      // Round-robin among cores, pointer wraps
      do_reset();
      req[1] = 4'h1;
      req[2] = 4'h2;
      req[3] = 4'h4;
      for (int c = 0; c < 4; c++) begin
         #2;
         check($sformatf("rr_gnt%0d", c), 64'(gnt), 64'(exp_t2[c]));
         tick();
      end

      // Write blocked against the snooped line, read passes
      do_reset();
      snoop_busy  = 1'b1;
      snoop_index = 8'h2A;
      addr[2] = 8'h2A; we[2] = 1'b1; req[2] = 4'h8;
      addr[3] = 8'h2A; req[3] = 4'h1;
      #2;
      check("blk_read_gnt", 64'(gnt), 64'h8);
      check("blk_read_we", 64'(sram_we), 64'h0);
      tick();
      req[3] = '0;
      #2;
      check("blk_wait_gnt", 64'(gnt), 64'h0);
      check("blk_wait_req", 64'(sram_req), 64'h0);
      tick();
      snoop_busy = 1'b0;
      #2;
      check("blk_write_gnt", 64'(gnt), 64'h4);
      check("blk_write_we", 64'(sram_we), 64'h1);
      check("blk_write_data", 64'(sram_data), 64'hD2);
      check("blk_write_be", 64'(sram_be), 64'hF2);
      tick();

      // Late tag follows previous winner
      do_reset();
      tag[1] = 12'h111;
      req[1] = 4'h1;
      #2;
      check("tag_n_gnt", 64'(gnt), 64'h2);
      tick();
      req[1] = '0;
      req[0] = 4'h2;
      tag[0] = 12'h5AA;
      #2;
      check("tag_n1_gnt", 64'(gnt), 64'h1);
      check("tag_n1_tag", 64'(sram_tag), 64'h111);
      tick();
      req[0] = '0;
      #2;
      check("tag_n2_tag", 64'(sram_tag), 64'h5AA);
      tick();

      // SRAM stall: no grants, state held
      do_reset();
      for (int r = 0; r < 4; r++) req[r] = 4'h1;
      sram_gnt = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         check($sformatf("stall_gnt%0d", c), 64'(gnt), 64'h0);
         check($sformatf("stall_addr%0d", c), 64'(sram_addr), 64'h10);
         tick();
      end
      check("stall_tag", 64'(sram_tag), 64'hA00);
      sram_gnt = 1'b1;
      #2;
      check("stall_rel_gnt", 64'(gnt), 64'h1);
      tick();
      req[0] = '0;
      #2;
      check("stall_rr_gnt", 64'(gnt), 64'h2);
      tick();
      #2;
      check("stall_snoop_grants", 64'(snoop_grants), PERF ? 64'd1 : 64'd0);
      check("stall_forced", 64'(starve_forced), 64'd0);

      // Reset mid-stream clears pointer, starvation count and counters
      do_reset();
      req[2] = 4'h1;
      #2;
      check("mid_core2_gnt", 64'(gnt), 64'h4);
      tick();
      req[2] = '0;
      req[0] = 4'h1; req[1] = 4'h1; req[3] = 4'h1;
      for (int c = 0; c < 3; c++) tick();
      rst_n = 1'b0;
      clear_inputs();
      #2;
      check("mid_rst_gnt", 64'(gnt), 64'h0);
      check("mid_rst_snoop_grants", 64'(snoop_grants), 64'h0);
      check("mid_rst_forced", 64'(starve_forced), 64'h0);
      tick();
      rst_n = 1'b1;
      req[0] = 4'h1; req[1] = 4'h1; req[3] = 4'h1;
      for (int c = 0; c < 5; c++) begin
         #2;
         check($sformatf("mid_post_gnt%0d", c), 64'(gnt), 64'(exp_t6[c]));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dcache_sram_arbiter.md
Name: dcache_sram_arbiter

Overview:
- Shares one dcache SRAM request port between the snoop cache controller (requester 0) and NrCorePorts core-side cache controllers (requesters 1..NrCorePorts).
- Snoop traffic gets fixed priority. A starvation counter bounds the wait on the core side. Core requesters are served round-robin among themselves.
- Holds the winner for one cycle so the late tag (valid one cycle after the request) is muxed from the correct requester.
- Blocks core writes that would modify the line a snoop is currently servicing.

Parameters:
- NrCorePorts, 3, number of core-side requesters.
- StarveMax, 4, consecutive snoop wins while a core request is pending before one core grant is forced.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- req_i  in  [NrCorePorts:0][DCACHE_SET_ASSOC-1:0]  per-requester way request vector; a requester is active if any bit is set
- addr_i  in  [NrCorePorts:0][DCACHE_INDEX_WIDTH-1:0]  per-requester index
- tag_i  in  [NrCorePorts:0][DCACHE_TAG_WIDTH-1:0]  per-requester tag, valid one cycle after grant
- we_i  in  [NrCorePorts:0]  write enable
- data_i  in  [NrCorePorts:0] cache_line_t  write data
- be_i  in  [NrCorePorts:0] cl_be_t  byte enables
- gnt_o  out  [NrCorePorts:0]  per-requester grant
- snoop_busy_i  in  1  snoop controller outside IDLE
- snoop_index_i  in  [DCACHE_INDEX_WIDTH-1:0]  index the snoop controller is servicing
- sram_req_o  out  [DCACHE_SET_ASSOC-1:0]  to SRAM
- sram_addr_o  out  [DCACHE_INDEX_WIDTH-1:0]
- sram_tag_o  out  [DCACHE_TAG_WIDTH-1:0]
- sram_we_o  out  1
- sram_data_o  out  cache_line_t
- sram_be_o  out  cl_be_t
- sram_gnt_i  in  1  SRAM accepts the request this cycle
- snoop_grants_o  out  16  perf counter (see Optional Feature)
- starve_forced_o  out  16  perf counter (see Optional Feature)

Behaviour:
- Reset state (rst_ni low, asynchronous): rr_ptr_q=0, starve_cnt_q=0, sel_q=0, counters=0.
- Combinational outputs during reset: all gnt_o=0 and sram_req_o=0 as long as no request is asserted.
- Eligibility:
  - Core requester i is blocked when we_i[i] & snoop_busy_i & (addr_i[i]==snoop_index_i).
  - Blocked requesters are treated as inactive. Core reads are never blocked.
- Winner selection (combinational, each cycle):
  - If the snoop is active and starve_cnt_q<StarveMax, or no eligible core request exists, the snoop wins.
  - Otherwise the first eligible core requester at or after rr_ptr_q (wrapping NrCorePorts-1 to 0) wins.
- SRAM outputs:
  - sram_req_o/addr/we/data/be = the winner's signals; all zero when nothing is active.
  - gnt_o[winner] = sram_gnt_i. Grant is the same cycle, zero latency.
  - A requester holds its request until granted. The arbiter keeps no lock across cycles.
- Tag phase:
  - On a grant, sel_q <= winner.
  - sram_tag_o = tag_i[sel_q] in the following cycle, independent of the current winner.
  - Back-to-back grants pipeline: the cycle-N grant's tag appears in cycle N+1 while the cycle-N+1 address is presented.
- Round-robin pointer: on a core grant of requester k, rr_ptr_q <= (k+1) mod NrCorePorts. It is unchanged otherwise.
- Starvation counter:
  - Increments (saturating at StarveMax) on a granted snoop while any eligible core request is pending.
  - Clears on any core grant, or when no core request is pending.
  - When starve_cnt_q==StarveMax and a core is eligible, that core wins even if the snoop is active.
- No grant without sram_gnt_i: pointer, counter and sel_q hold.
- Reset mid-transfer: state returns to reset values; a pending tag phase is dropped. Requesters are reset by the same reset.

Optional Feature:
- Macro DCACHE_ARB_PERF_EN.
- Defined:
  - snoop_grants_o counts granted snoop cycles.
  - starve_forced_o counts forced core grants, i.e. a core won while the snoop was active.
  - Both are 16-bit saturating counters, reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- std_cache_pkg gains arb_sel_t (logic [$clog2(NrCorePorts+1)-1:0]) and constant DCACHE_SNOOP_PORT=0.
- One sub-module, rr_pick: find-first-from-pointer over an eligibility vector; returns index and valid.

Test Plan:
- Snoop and core1 request together, sram_gnt_i=1 every cycle, StarveMax=4 → grants S,S,S,S,core1, then S; starve_forced_o=1.
- Cores 1,2,3 request continuously, no snoop → grant order 1,2,3,1; rr_ptr wraps 2→0.
- snoop_busy_i=1 with snoop_index_i=0x2A; core2 write to 0x2A and core3 read to 0x2A → core3 granted, core2 waits until snoop_busy_i drops, then granted.
- Grant core1 (tag 0x111) in cycle N and snoop (tag 0x5AA) in cycle N+1 → sram_tag_o=0x111 in N+1, 0x5AA in N+2.
- sram_gnt_i=0 for 3 cycles with all requesters active → no gnt_o, counters/pointer unchanged, sram_addr_o shows the snoop address.
- Assert rst_ni low mid-stream for 1 cycle → gnt_o=0, rr_ptr_q=0, starve_cnt_q=0, perf counters=0.
